root_job_sequencer: RTL and testbench

- Upstream driver for a compiled root evaluator (ST/RD/RES, two 16-bit operands).
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Launches the evaluator once per pair and holds its operands stable.
- Captures RES on completion and presents it on a valid/ready result stream; evaluations are strictly serialized.

---
 rtl/root_job_sequencer.sv | 178 +++++++++++++++++
 tb/tb_root_job_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/root_job_sequencer.sv
// Operand-pair FIFO and launch/capture sequencer for a start/ready root evaluator.
// Optional RD watchdog with sticky ERR output: define ROOT_JOB_SEQUENCER_TIMEOUT_EN.
module root_job_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    output logic             N_ST,
    output logic [WIDTH-1:0] N_IN0,
    output logic [WIDTH-1:0] N_IN1,
    input  logic             N_RD,
    input  logic [WIDTH-1:0] N_RES,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_RES,
    output logic             BUSY,
`ifdef ROOT_JOB_SEQUENCER_TIMEOUT_EN
    output logic             ERR,
`endif
    output logic [15:0]      JOB_CNT
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    // Pointer wrap relies on natural binary overflow, hence the power-of-2 requirement.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("root_job_sequencer: DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("root_job_sequencer: TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;

`ifdef ROOT_JOB_SEQUENCER_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmo_cnt;
`endif

    // Pop only happens on a load edge, which sees the registered count: no bypass path.
    always_comb begin
        fifo_nonempty = (count != '0);
        push          = IN_VALID && IN_READY;
        pop           = 1'b0;
        case (state)
            S_IDLE:  pop = fifo_nonempty;
            S_HOLD:  pop = OUT_READY && fifo_nonempty;
            default: pop = 1'b0;
        endcase
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        BUSY = (state != S_IDLE) || fifo_nonempty;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_a[wr_ptr] <= IN_A;
            mem_b[wr_ptr] <= IN_B;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            IN_READY  <= 1'b0;
            N_ST      <= 1'b0;
            N_IN0     <= '0;
            N_IN1     <= '0;
            OUT_VALID <= 1'b0;
            OUT_RES   <= '0;
            JOB_CNT   <= '0;
`ifdef ROOT_JOB_SEQUENCER_TIMEOUT_EN
            ERR       <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            count    <= count_next;
            IN_READY <= (count_next < CW'(DEPTH));

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                N_IN0  <= mem_a[rd_ptr];
                N_IN1  <= mem_b[rd_ptr];
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        N_ST  <= 1'b1;
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    N_ST  <= 1'b0;
                    state <= S_ARM;
                end
                S_ARM: begin
                    // RD is deliberately not looked at here: it may still be high from the last job.
                    state <= S_WAIT;
`ifdef ROOT_JOB_SEQUENCER_TIMEOUT_EN
                    tmo_cnt <= TW'(TIMEOUT - 1);
`endif
                end
                S_WAIT: begin
                    if (N_RD) begin
                        OUT_RES   <= N_RES;
                        OUT_VALID <= 1'b1;
                        JOB_CNT   <= JOB_CNT + 16'd1;
                        state     <= S_HOLD;
                    end
`ifdef ROOT_JOB_SEQUENCER_TIMEOUT_EN
                    else if (tmo_cnt == '0) begin
                        ERR       <= 1'b1;
                        OUT_RES   <= '0;
                        OUT_VALID <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
`endif
                end
                S_HOLD: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        if (pop) begin
                            N_ST  <= 1'b1;
                            state <= S_LAUNCH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    N_ST  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_root_job_sequencer.sv
// Scoreboard bench for root_job_sequencer: evaluator model computes a fixed
// non-commutative function of its operands; expected results queue in accept order.
module tb_root_job_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        n_st;
    logic [15:0] n_in0;
    logic [15:0] n_in1;
    logic        n_rd = 1'b0;
    logic [15:0] n_res = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_res;
    logic        busy;
    logic [15:0] job_cnt;
`ifdef ROOT_JOB_SEQUENCER_TIMEOUT_EN
    logic        err;
`endif

    root_job_sequencer #(.WIDTH(16), .DEPTH(4), .TIMEOUT(1024)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_A      (in_a),
        .IN_B      (in_b),
        .N_ST      (n_st),
        .N_IN0     (n_in0),
        .N_IN1     (n_in1),
        .N_RD      (n_rd),
        .N_RES     (n_res),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_RES   (out_res),
        .BUSY      (busy),
`ifdef ROOT_JOB_SEQUENCER_TIMEOUT_EN
        .ERR       (err),
`endif
        .JOB_CNT   (job_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_q [$];
    int unsigned model_jobs = 0;
    int unsigned accepted = 0;
    int unsigned st_count = 0;

    // Evaluator controls
    logic        eval_en = 1'b1;
    logic        rd_stuck = 1'b0;
    logic        eval_lat_rand = 1'b0;
    int unsigned eval_lat = 4;
    // Result-consumer controls
    logic        rand_ready = 1'b0;
    logic        forced_ready = 1'b1;

    function automatic logic [15:0] root_fn(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic [15:0] t;
        s = a + b;
        t = a >> 4;
        t = t << 8;
        return s ^ t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int unsigned t = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            exp_q.push_back(root_fn(a, b));
            accepted++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int unsigned bound);
        int unsigned t = 0;
        while ((exp_q.size() != 0 || busy) && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    // Result consumer
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
        end
    end

    // Evaluator model: RD drops on ST, result appears after a latency
    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int unsigned lat;
        forever begin
            @(negedge clk);
            if (eval_en && n_st && !rst) begin
                a = n_in0;
                b = n_in1;
                if (rd_stuck) begin
                    repeat (2) @(negedge clk);
                    n_res = root_fn(a, b);
                end else begin
                    n_rd = 1'b0;
                    lat  = eval_lat_rand ? $urandom_range(1, 6) : eval_lat;
                    repeat (lat) @(negedge clk);
                    n_res = root_fn(a, b);
                    n_rd  = 1'b1;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        prev_st = 1'b0;
        logic        hold_prev = 1'b0;
        logic [15:0] prev_res = '0;
        logic [15:0] prev_in0 = '0;
        logic [15:0] prev_in1 = '0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_st   = 1'b0;
                hold_prev = 1'b0;
                prev_in0  = '0;
                prev_in1  = '0;
                continue;
            end
            if (n_st) begin
                st_count++;
                chk("st_single_cycle", 32'(prev_st), 32'd0);
                chk("st_while_result_pending", 32'(out_valid), 32'd0);
            end
            if (n_in0 !== prev_in0 || n_in1 !== prev_in1) begin
                chk("operands_change_only_on_load", 32'(n_st), 32'd1);
            end
            if (hold_prev && out_valid) begin
                chk("out_res_stable", 32'(out_res), 32'(prev_res));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 32'(out_res), 32'(e));
                    model_jobs++;
                    chk("job_cnt", 32'(job_cnt), 32'(model_jobs[15:0]));
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_res  = out_res;
            prev_st   = n_st;
            prev_in0  = n_in0;
            prev_in1  = n_in1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        int unsigned st0;
        logic [15:0] held;

        // Reset and idle
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_n_st", 32'(n_st), 32'd0);
        chk("rst_n_in0", 32'(n_in0), 32'd0);
        chk("rst_n_in1", 32'(n_in1), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_res", 32'(out_res), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_job_cnt", 32'(job_cnt), 32'd0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 32'd1);
            chk("idle_n_st", 32'(n_st), 32'd0);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_job_cnt", 32'(job_cnt), 32'd0);
        end

        // Single job, RD four cycles after ST
        eval_lat = 4;
        st0 = st_count;
        push(16'h0003, 16'h0005);
        drain(200);
        chk("single_st_pulses", st_count - st0, 32'd1);
        chk("single_n_in0", 32'(n_in0), 32'h0003);
        chk("single_n_in1", 32'(n_in1), 32'h0005);
        chk("single_out_res", 32'(out_res), 32'h0008);
        chk("single_job_cnt", 32'(job_cnt), 32'd1);

        // Five pairs against a stalled evaluator
        eval_lat = 30;
        for (int i = 0; i < 5; i++) begin
            push(16'(16'h0100 * (i + 1) + 16'h0011), 16'(16'h0023 + i));
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        drain(1000);

        // RD held high across jobs
        n_rd = 1'b1;
        rd_stuck = 1'b1;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push(16'($urandom), 16'($urandom));
        end
        drain(500);
        rd_stuck = 1'b0;

        // Result held with consumer stalled, then launch on handshake edge
        eval_lat = 2;
        forced_ready = 1'b0;
        push(16'h1234, 16'h0101);
        push(16'h0F0F, 16'h00FF);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("stall_valid_seen", 32'(out_valid), 32'd1);
        held = out_res;
        st0 = st_count;
        repeat (10) begin
            @(negedge clk);
            chk("stall_res_stable", 32'(out_res), 32'(held));
            chk("stall_valid_held", 32'(out_valid), 32'd1);
        end
        chk("stall_no_launch", st_count - st0, 32'd0);
        forced_ready = 1'b1;
        t = 0;
        while (!(out_valid && out_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("stall_handshake_seen", 32'(out_ready), 32'd1);
        @(negedge clk);
        chk("launch_on_handshake", 32'(n_st), 32'd1);
        drain(200);

        // Randomized traffic
        rand_ready = 1'b1;
        eval_lat_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(16'($urandom), 16'($urandom));
        end
        drain(2000);
        rand_ready = 1'b0;
        forced_ready = 1'b1;
        eval_lat_rand = 1'b0;
        @(negedge clk);
        chk("launch_count", st_count, accepted);

        // Reset while waiting for RD, then a late RD
        eval_en = 1'b0;
        n_rd = 1'b0;
        push(16'h1111, 16'h2222);
        t = 0;
        while (!n_st && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("abort_st_seen", 32'(n_st), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_jobs = 0;
        @(negedge clk);
        rst = 1'b0;
        n_res = 16'hBEEF;
        n_rd = 1'b1;
        repeat (2) @(negedge clk);
        n_rd = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_out_valid", 32'(out_valid), 32'd0);
            chk("abort_job_cnt", 32'(job_cnt), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_out_res", 32'(out_res), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
